// File: rtl/modulation_pkg.sv
// modulation_pkg: precharge switch levels, mode codes and sequencer states
// shared by the az modulation sequencer and its bench.
package modulation_pkg;
    localparam logic SW_PC_SIGNAL = 1'b1;
    localparam logic SW_PC_BOOT   = 1'b0;
    typedef enum logic [1:0] {MODE_OFF, MODE_NOAZ, MODE_AZ, MODE_MULTI} mode_t;
    typedef enum logic [2:0] {
        ST_IDLE, ST_PROTECT, ST_SETTLE, ST_SAMPLE_HI, ST_REPROTECT, ST_SAMPLE_LO, ST_NEXT
    } state_t;
endpackage

// File: rtl/interval_timer.sv
// interval_timer: loads an interval of n clocks (0 counts as 1), counts down and
// flags the final clock; holds at zero until reloaded.
module interval_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] n,
    output logic             done
);
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (!reset) r_cnt <= '0;
        else if (load) r_cnt <= (n == '0) ? '0 : n - 1'b1;
        else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
    assign done = (r_cnt == '0);
endmodule

// File: rtl/modulation_az_seq.sv
// modulation_az_seq: auto-zero modulation sequencer driving the precharge switch
// and az mux through protect/settle/hi-sample/reprotect/lo-sample cycles.
module modulation_az_seq
    import modulation_pkg::*;
#(
    parameter int CNT_W   = 24,
    parameter int MUX_W   = 4,
    parameter int N_PHASE = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic [1:0]                 mode,
    input  logic [N_PHASE*MUX_W-1:0]   azmux_val,
    input  logic [CNT_W-1:0]           clk_count_sample_n,
    input  logic [CNT_W-1:0]           clk_count_precharge_n,
    output logic                       sw_pc_ctl,
    output logic [MUX_W-1:0]           azmux,
    output logic                       sample_active,
    output logic                       sample_done,
    output logic [$clog2(N_PHASE)-1:0] phase_idx,
    output logic                       led0,
    output logic [7:0]                 monitor
);
    localparam int PW = $clog2(N_PHASE);
    state_t           r_state, w_next;
    mode_t            r_mode, w_mode, w_in_mode;
    logic [PW-1:0]    r_phase, w_phase;
    logic             r_pc, w_pc, r_hi, w_hi, w_load, w_done;
    logic [MUX_W-1:0] r_az, w_az;
    logic [CNT_W-1:0] w_n;
    assign w_in_mode = mode_t'(mode);
    assign w_n = (w_next == ST_SAMPLE_HI || w_next == ST_SAMPLE_LO) ? clk_count_sample_n : clk_count_precharge_n;
    interval_timer #(.CNT_W(CNT_W)) u_timer (
        .clk(clk), .reset(reset), .load(w_load), .n(w_n), .done(w_done)
    );
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_OFF;
            r_phase <= '0;
            r_pc    <= SW_PC_BOOT;
            r_hi    <= 1'b0;
            r_az    <= '0;
        end else begin
            r_state <= w_next;
            r_mode  <= w_mode;
            r_phase <= w_phase;
            r_pc    <= w_pc;
            r_hi    <= w_hi;
            r_az    <= w_az;
        end
    end
    // Switch and mux hold their last applied value in states that do not drive them.
    always_comb begin
        w_next  = r_state;
        w_mode  = r_mode;
        w_phase = r_phase;
        w_load  = 1'b0;
        w_pc    = r_pc;
        w_az    = r_az;
        w_hi    = r_hi;
        case (r_state)
            ST_IDLE: begin
                w_pc = SW_PC_BOOT;
                w_az = '0;
                w_hi = 1'b0;
                if (run && w_in_mode != MODE_OFF) begin
                    w_mode = w_in_mode;
                    w_next = ST_PROTECT;
                end
            end
            ST_PROTECT: begin
                w_pc = SW_PC_BOOT;
                if (w_done) w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_az = azmux_val[MUX_W-1:0];
                w_hi = 1'b1;
                if (w_done) w_next = ST_SAMPLE_HI;
            end
            ST_SAMPLE_HI: begin
                w_pc = SW_PC_SIGNAL;
                w_az = azmux_val[MUX_W-1:0];
                w_hi = 1'b1;
                if (w_done) w_next = (r_mode == MODE_NOAZ) ? ST_NEXT : ST_REPROTECT;
            end
            ST_REPROTECT: begin
                w_pc = SW_PC_BOOT;
                if (w_done) begin
                    w_next  = ST_SAMPLE_LO;
                    w_phase = PW'(1);
                end
            end
            ST_SAMPLE_LO: begin
                w_az = azmux_val[r_phase*MUX_W +: MUX_W];
                w_hi = 1'b0;
                if (w_done) begin
                    if (r_mode == MODE_MULTI && r_phase != PW'(N_PHASE-1)) begin
                        w_phase = r_phase + 1'b1;
                        w_load  = 1'b1;
                    end else w_next = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (!run || w_in_mode == MODE_OFF) w_next = ST_IDLE;
                else if (w_in_mode != r_mode) begin
                    w_mode = w_in_mode;
                    w_next = ST_PROTECT;
                end else w_next = (r_mode == MODE_NOAZ) ? ST_SAMPLE_HI : ST_SETTLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_next == ST_SAMPLE_HI) w_phase = '0;
        if (w_next != r_state && w_next != ST_IDLE && w_next != ST_NEXT) w_load = 1'b1;
    end
    assign sw_pc_ctl     = w_pc;
    assign azmux         = w_az;
    assign sample_active = (r_state == ST_SAMPLE_HI || r_state == ST_SAMPLE_LO);
    assign sample_done   = sample_active && w_done;
    assign phase_idx     = r_phase;
    assign led0          = (r_state == ST_SAMPLE_HI);
    assign monitor       = {4'b0, r_state == ST_NEXT, sample_active, w_pc == SW_PC_SIGNAL, w_hi};
endmodule

// File: doc/modulation_az_seq.md
MODULATION_AZ_SEQ -- requirements
Module: modulation_az_seq

Interface
REQ-001 Parameters SHALL be `CNT_W` (default 24, interval counter width), `MUX_W` (default 4, mux code width) and `N_PHASE` (default 4, maximum phases per cycle, >=2).
REQ-002 Ports SHALL be:
- `clk`  in  1  system clock, 20 MHz
- `reset`  in  1  synchronous active-low reset
- `run`  in  1  enable; sampled only at cycle boundary
- `mode`  in  2  0 OFF, 1 NOAZ, 2 AZ, 3 MULTI; sampled only at cycle boundary
- `azmux_val`  in  N_PHASE*MUX_W  per-phase mux code; slice 0 = hi (pc-out, normally S1 = 4'b1000), slices 1.. = lo/aux inputs
- `clk_count_sample_n`  in  CNT_W  sample interval length in clocks
- `clk_count_precharge_n`  in  CNT_W  protect/settle interval length in clocks
- `sw_pc_ctl`  out  1  precharge switch: 1 SIGNAL, 0 BOOT
- `azmux`  out  MUX_W  az mux code
- `sample_active`  out  1  high during every sample interval
- `sample_done`  out  1  one-clock pulse on the last clock of each sample interval
- `phase_idx`  out  clog2(N_PHASE)  phase of the current or just-finished sample
- `led0`  out  1  high during hi sample
- `monitor`  out  8  debug: [0] azmux=hi, [1] pc=SIGNAL, [2] sample_active, [3] cycle start pulse, [7:4] 0

Function
REQ-003 States SHALL be: IDLE, PROTECT, SETTLE, SAMPLE_HI, REPROTECT, SAMPLE_LO, NEXT.
REQ-004 Each timed state SHALL last exactly n clocks, where n is the interval value latched on entry; an n of 0 SHALL be treated as 1.
REQ-005 Interval inputs SHALL be latched on entry to each timed state; later changes SHALL NOT affect an interval already running.
REQ-006 IDLE SHALL hold `sw_pc_ctl`=BOOT. If `run`=1 and `mode`!=OFF, IDLE SHALL latch `mode` and go to PROTECT.
REQ-007 PROTECT (precharge_n) SHALL set `sw_pc_ctl`=BOOT, then go to SETTLE.
REQ-008 SETTLE (precharge_n) SHALL set `azmux`=slice 0 and `monitor[0]`=1, then go to SAMPLE_HI.
REQ-009 SAMPLE_HI (sample_n) SHALL set `sw_pc_ctl`=SIGNAL, `led0`=1, `phase_idx`=0 and `sample_active`=1.
REQ-010 On leaving SAMPLE_HI in NOAZ mode, the block SHALL go to NEXT with the pc switch still at SIGNAL; in all other modes it SHALL go to REPROTECT.
REQ-011 REPROTECT (precharge_n) SHALL set `sw_pc_ctl`=BOOT, then go to SAMPLE_LO with phase p=1.
REQ-012 SAMPLE_LO (sample_n) SHALL set `azmux`=slice p, `phase_idx`=p, `led0`=0, `monitor[0]`=0 and `sample_active`=1.
REQ-013 On leaving SAMPLE_LO, AZ mode SHALL go to NEXT. MULTI mode SHALL increment p and re-enter SAMPLE_LO until p=N_PHASE-1 has been sampled, then go to NEXT.
REQ-014 NEXT (1 clock) SHALL pulse `monitor[3]` and re-sample `run` and `mode`:
- `run`=0 or `mode`=OFF: go to IDLE.
- same mode: go to SETTLE; NOAZ SHALL skip SETTLE and go straight to SAMPLE_HI.
- changed mode: go to PROTECT.
REQ-015 `sample_done` SHALL be asserted combinationally-aligned with the final clock of each sample interval, together with a valid `phase_idx`.
REQ-016 Deasserting `run` mid-cycle SHALL NOT truncate the cycle; the current cycle SHALL complete first.
REQ-017 The hi mux code SHALL never be applied while `sw_pc_ctl`=SIGNAL, except during SAMPLE_HI, and NEXT/SETTLE in NOAZ.

Reset
REQ-018 While `reset`=0 at a rising edge, the next state SHALL be IDLE with:
- `sw_pc_ctl`=BOOT, `azmux`=0, `led0`=0, `monitor`=0
- `sample_active`=0, `sample_done`=0, `phase_idx`=0, counter=0
REQ-019 Reset asserted in any state, including mid-interval, SHALL take effect on the next edge without completing the interval.

Structure
REQ-020 Package `modulation_pkg` SHALL hold `SW_PC_SIGNAL`/`SW_PC_BOOT`, the mode encodings and the state encoding.
REQ-021 Interval timing SHALL be a sub-module `interval_timer`: load, count down, and a `done` output asserted on the final clock.
REQ-022 The counter SHALL be CNT_W bits and SHALL NOT wrap; it holds at 0 until reloaded.

Verification
REQ-023 AZ, precharge_n=3, sample_n=5, run=1: sequence is PROTECT 3, SETTLE 3, HI 5, REPROTECT 3, LO 5, NEXT 1 clocks; `sample_done` at phases 0 then 1; cycle period 17 clocks.
REQ-024 MULTI, N_PHASE=4, slices {8,1,2,3}: `azmux` takes 8,1,2,3 in order; `phase_idx` 0..3; four `sample_done` pulses per cycle.
REQ-025 NOAZ: `sw_pc_ctl` stays SIGNAL across NEXT; the steady-state period is sample_n+1.
REQ-026 `run` dropped during SAMPLE_HI in AZ: SAMPLE_LO still completes, then IDLE with pc=BOOT.
REQ-027 `reset`=0 mid SAMPLE_LO: all outputs equal the REQ-018 values one clock later.
REQ-028 sample_n=0: each interval lasts 1 clock; a mode change at NEXT forces PROTECT.
